// File: rtl/i2s_tdm_clk_gen.sv
// i2s_tdm_clk_gen: I2S / left-justified / DSP bit- and frame-clock generator.
//   Divides the master clock into bclk and a word-select / frame-sync (lrck) and provides
//   per-bit strobes plus slot/bit indices for a serialiser/deserialiser. Configuration is
//   shadowed and only swapped at a frame boundary, so an in-flight frame is never disturbed.
// Ports:
//   i_mclki        master clock, all logic on its rising edge
//   i_rst_n        asynchronous active-low reset
//   i_enable       1 = run, 0 = stop at the end of the current frame
//   i_bclk_div     bclk half-period in mclki cycles (1..MAX_DIV)
//   i_word_width   slot width in bits (8..32)
//   i_ch_num       slots per frame (2..MAX_CH, even)
//   i_fmt          0 = I2S, 1 = left-justified, 2 = DSP mode A, 3 = invalid
//   o_bclk         bit clock
//   o_lrck         word select / frame sync
//   o_bclk_fall    strobe with bclk going low (bit start)
//   o_bclk_rise    strobe with bclk going high (sample point)
//   o_frame_start  strobe on the bclk_fall of slot 0, bit 0
//   o_slot_idx     current slot
//   o_bit_idx      current bit in slot, 0 = MSB
//   o_running      1 while running or stopping
//   o_cfg_err      one-cycle pulse when a sampled configuration is invalid
`timescale 1ns / 1ps
module i2s_tdm_clk_gen #(
  parameter int unsigned MAX_CH  = 16,
  parameter int unsigned MAX_DIV = 64
) (
  input  logic                      i_mclki,
  input  logic                      i_rst_n,
  input  logic                      i_enable,
  input  logic [6:0]                i_bclk_div,
  input  logic [5:0]                i_word_width,
  input  logic [4:0]                i_ch_num,
  input  logic [1:0]                i_fmt,
  output logic                      o_bclk,
  output logic                      o_lrck,
  output logic                      o_bclk_fall,
  output logic                      o_bclk_rise,
  output logic                      o_frame_start,
  output logic [$clog2(MAX_CH)-1:0] o_slot_idx,
  output logic [4:0]                o_bit_idx,
  output logic                      o_running,
  output logic                      o_cfg_err
);

  localparam int unsigned SW     = $clog2(MAX_CH);
  localparam int unsigned DW     = $clog2(MAX_DIV + 1);
  localparam logic [6:0]  MaxDiv = 7'(MAX_DIV);
  localparam logic [4:0]  MaxCh  = 5'(MAX_CH);
  localparam logic [1:0]  FmtI2s = 2'd0;
  localparam logic [1:0]  FmtLj  = 2'd1;
  localparam logic [1:0]  FmtDsp = 2'd2;

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e        r_state;
  logic          r_en;
  logic [6:0]    r_div, r_sh_div;
  logic [5:0]    r_ww, r_sh_ww;
  logic [4:0]    r_ch, r_sh_ch;
  logic [1:0]    r_fmt, r_sh_fmt;
  logic [DW-1:0] r_cnt;
  logic          r_err_hold;
  logic [19:0]   r_err_cfg;

  logic [19:0]   w_cfg;
  logic          w_cfg_ok, w_tc, w_last_bit, w_last_slot;
  logic [SW-1:0] w_nslot;
  logic [4:0]    w_nbit;

  // lrck level for the bit period starting at (slot, bitn) under a given framing.
  function automatic logic lrck_at(input logic [1:0] fmt, input logic [4:0] ch,
                                   input logic [5:0] ww, input logic [4:0] slot,
                                   input logic [4:0] bitn);
    logic [4:0] h;
    logic       lb;
    logic       res;
    h  = ch >> 1;
    lb = ({1'b0, bitn} == ww - 6'd1);
    case (fmt)
      FmtLj:   res = (slot < h);
      // I2S leads the slot by one bclk: flips on the last bit of slots h-1 and ch-1
      FmtI2s:  res = ((slot >= h) && !((slot == ch - 5'd1) && lb)) ||
                     ((slot == h - 5'd1) && lb);
      FmtDsp:  res = (slot == ch - 5'd1) && lb;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign w_cfg       = {r_div, r_ww, r_ch, r_fmt};
  assign w_cfg_ok    = (r_div != 7'd0) && (r_div <= MaxDiv) &&
                       (r_ww >= 6'd8) && (r_ww <= 6'd32) &&
                       (r_ch >= 5'd2) && (r_ch <= MaxCh) && !r_ch[0] &&
                       (r_fmt != 2'd3);
  assign w_tc        = (r_cnt == DW'(r_sh_div - 7'd1));
  assign w_last_bit  = ({1'b0, o_bit_idx} == r_sh_ww - 6'd1);
  assign w_last_slot = (5'(o_slot_idx) == r_sh_ch - 5'd1);

  always_comb begin
    w_nbit  = o_bit_idx + 5'd1;
    w_nslot = o_slot_idx;
    if (w_last_bit) begin
      w_nbit  = '0;
      w_nslot = w_last_slot ? '0 : o_slot_idx + SW'(1);
    end
  end

  always_ff @(posedge i_mclki or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_en          <= 1'b0;
      r_div         <= '0;
      r_ww          <= '0;
      r_ch          <= '0;
      r_fmt         <= '0;
      r_sh_div      <= '0;
      r_sh_ww       <= '0;
      r_sh_ch       <= '0;
      r_sh_fmt      <= '0;
      r_cnt         <= '0;
      r_err_hold    <= 1'b0;
      r_err_cfg     <= '0;
      o_bclk        <= 1'b0;
      o_lrck        <= 1'b0;
      o_bclk_fall   <= 1'b0;
      o_bclk_rise   <= 1'b0;
      o_frame_start <= 1'b0;
      o_slot_idx    <= '0;
      o_bit_idx     <= '0;
      o_running     <= 1'b0;
      o_cfg_err     <= 1'b0;
    end else begin
      r_en          <= i_enable;
      r_div         <= i_bclk_div;
      r_ww          <= i_word_width;
      r_ch          <= i_ch_num;
      r_fmt         <= i_fmt;
      o_bclk_fall   <= 1'b0;
      o_bclk_rise   <= 1'b0;
      o_frame_start <= 1'b0;
      o_cfg_err     <= 1'b0;
      case (r_state)
        StIdle: begin
          if (!r_en) begin
            r_err_hold <= 1'b0;
          end else if (w_cfg_ok) begin
            r_sh_div      <= r_div;
            r_sh_ww       <= r_ww;
            r_sh_ch       <= r_ch;
            r_sh_fmt      <= r_fmt;
            r_err_hold    <= 1'b0;
            r_cnt         <= '0;
            r_state       <= StRun;
            o_running     <= 1'b1;
            o_bclk        <= 1'b0;
            o_bclk_fall   <= 1'b1;
            o_frame_start <= 1'b1;
            o_slot_idx    <= '0;
            o_bit_idx     <= '0;
            o_lrck        <= lrck_at(r_fmt, r_ch, r_ww, 5'd0, 5'd0);
          end else if (!r_err_hold || (w_cfg != r_err_cfg)) begin
            // Report a given bad configuration once, not every cycle it persists
            o_cfg_err  <= 1'b1;
            r_err_hold <= 1'b1;
            r_err_cfg  <= w_cfg;
          end
        end
        StRun: begin
          if (!w_tc) begin
            r_cnt <= r_cnt + DW'(1);
          end else begin
            r_cnt <= '0;
            if (!o_bclk) begin
              o_bclk      <= 1'b1;
              o_bclk_rise <= 1'b1;
            end else if (w_last_bit && w_last_slot) begin
              o_bclk     <= 1'b0;
              o_slot_idx <= '0;
              o_bit_idx  <= '0;
              if (!r_en) begin
                r_state <= StStop;
                o_lrck  <= 1'b0;
              end else begin
                o_bclk_fall   <= 1'b1;
                o_frame_start <= 1'b1;
                if (w_cfg_ok) begin
                  r_sh_div <= r_div;
                  r_sh_ww  <= r_ww;
                  r_sh_ch  <= r_ch;
                  r_sh_fmt <= r_fmt;
                  o_lrck   <= lrck_at(r_fmt, r_ch, r_ww, 5'd0, 5'd0);
                end else begin
                  o_cfg_err <= 1'b1;
                  o_lrck    <= lrck_at(r_sh_fmt, r_sh_ch, r_sh_ww, 5'd0, 5'd0);
                end
              end
            end else begin
              o_bclk      <= 1'b0;
              o_bclk_fall <= 1'b1;
              o_slot_idx  <= w_nslot;
              o_bit_idx   <= w_nbit;
              o_lrck      <= lrck_at(r_sh_fmt, r_sh_ch, r_sh_ww, 5'(w_nslot), w_nbit);
            end
          end
        end
        StStop: begin
          r_state   <= StIdle;
          o_running <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_tdm_clk_gen.sv
`timescale 1ns / 1ps
module tb_i2s_tdm_clk_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] div = 7'd2;
  logic [5:0] ww = 6'd32;
  logic [4:0] ch = 5'd2;
  logic [1:0] fmt = 2'd0;
  logic       bclk, lrck, fall, rise, fs, running, cfg_err;
  logic [3:0] slot;
  logic [4:0] bitn;
  logic [13:0] obs;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  i2s_tdm_clk_gen #(.MAX_CH(16), .MAX_DIV(64)) dut (
    .i_mclki       (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_bclk_div    (div),
    .i_word_width  (ww),
    .i_ch_num      (ch),
    .i_fmt         (fmt),
    .o_bclk        (bclk),
    .o_lrck        (lrck),
    .o_bclk_fall   (fall),
    .o_bclk_rise   (rise),
    .o_frame_start (fs),
    .o_slot_idx    (slot),
    .o_bit_idx     (bitn),
    .o_running     (running),
    .o_cfg_err     (cfg_err)
  );

  assign obs = {bclk, lrck, fall, rise, fs, slot, bitn};

  typedef struct {
    string      name;
    logic [1:0] fmt;
    logic [4:0] ch;
    logic [5:0] ww;
    logic [6:0] div;
    int         t;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [13:0] ex(input logic b, input logic l, input logic f,
                                     input logic r, input logic s, input logic [3:0] sl,
                                     input logic [4:0] bi);
    return {b, l, f, r, s, sl, bi};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_fs(input string nm, output logic ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (cyc < 64 && !ok) begin
      tick();
      cyc++;
      if (fs === 1'b1) ok = 1'b1;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: frame_start not seen within %0d cycles", nm, cyc);
    end
  endtask

  // Reset, load a config, enable, and return aligned to the first frame_start sample.
  task automatic start(input logic [1:0] f, input logic [4:0] c, input logic [5:0] w,
                       input logic [6:0] d, input string nm);
    logic ok;
    int   cyc;
    rst_n  = 1'b0;
    enable = 1'b0;
    fmt = f; ch = c; ww = w; div = d;
    #2;
    rst_n  = 1'b1;
    enable = 1'b1;
    wait_fs(nm, ok, cyc);
  endtask

  task automatic add(input string nm, input logic [1:0] f, input logic [4:0] c,
                     input logic [5:0] w, input logic [6:0] d, input int t,
                     input logic [13:0] e);
    vec_t v;
    v.name = nm; v.fmt = f; v.ch = c; v.ww = w; v.div = d; v.t = t; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   cyc, glitch, extra, pulses, run_seen;

    // I2S stereo 32-bit, div 2
    add("t1_fs",       0, 2, 32, 2,   0, ex(0, 0, 1, 0, 1, 0, 0));
    add("t1_t1",       0, 2, 32, 2,   1, ex(0, 0, 0, 0, 0, 0, 0));
    add("t1_rise",     0, 2, 32, 2,   2, ex(1, 0, 0, 1, 0, 0, 0));
    add("t1_bit1",     0, 2, 32, 2,   4, ex(0, 0, 1, 0, 0, 0, 1));
    add("t1_b30_hi",   0, 2, 32, 2, 123, ex(1, 0, 0, 0, 0, 0, 30));
    add("t1_lr_up",    0, 2, 32, 2, 124, ex(0, 1, 1, 0, 0, 0, 31));
    add("t1_slot1",    0, 2, 32, 2, 128, ex(0, 1, 1, 0, 0, 1, 0));
    add("t1_s1b30",    0, 2, 32, 2, 250, ex(1, 1, 0, 1, 0, 1, 30));
    add("t1_lr_dn",    0, 2, 32, 2, 252, ex(0, 0, 1, 0, 0, 1, 31));
    add("t1_fs2",      0, 2, 32, 2, 256, ex(0, 0, 1, 0, 1, 0, 0));
    // TDM8 DSP, div 1
    add("t2_fs",       2, 8, 32, 1,   0, ex(0, 0, 1, 0, 1, 0, 0));
    add("t2_rise",     2, 8, 32, 1,   1, ex(1, 0, 0, 1, 0, 0, 0));
    add("t2_slot1",    2, 8, 32, 1,  64, ex(0, 0, 1, 0, 0, 1, 0));
    add("t2_s7b30",    2, 8, 32, 1, 509, ex(1, 0, 0, 1, 0, 7, 30));
    add("t2_sync_a",   2, 8, 32, 1, 510, ex(0, 1, 1, 0, 0, 7, 31));
    add("t2_sync_b",   2, 8, 32, 1, 511, ex(1, 1, 0, 1, 0, 7, 31));
    add("t2_fs2",      2, 8, 32, 1, 512, ex(0, 0, 1, 0, 1, 0, 0));
    // Left-justified, 4 slots of 16, div 3
    add("lj_fs",       1, 4, 16, 3,   0, ex(0, 1, 1, 0, 1, 0, 0));
    add("lj_s1b15",    1, 4, 16, 3, 186, ex(0, 1, 1, 0, 0, 1, 15));
    add("lj_s2b0",     1, 4, 16, 3, 192, ex(0, 0, 1, 0, 0, 2, 0));
    add("lj_s2rise",   1, 4, 16, 3, 195, ex(1, 0, 0, 1, 0, 2, 0));
    add("lj_s3b15",    1, 4, 16, 3, 383, ex(1, 0, 0, 0, 0, 3, 15));
    add("lj_fs2",      1, 4, 16, 3, 384, ex(0, 1, 1, 0, 1, 0, 0));
    // I2S with minimum word width
    add("ww8_lr_up",   0, 2,  8, 1,  14, ex(0, 1, 1, 0, 0, 0, 7));
    add("ww8_lr_dn",   0, 2,  8, 1,  30, ex(0, 0, 1, 0, 0, 1, 7));
    add("ww8_fs2",     0, 2,  8, 1,  32, ex(0, 0, 1, 0, 1, 0, 0));

    // Reset state
    #1 rst_n = 1'b0;
    tick();
    check("reset_state", {obs, running, cfg_err}, 0);

    foreach (vecs[i]) begin
      start(vecs[i].fmt, vecs[i].ch, vecs[i].ww, vecs[i].div, vecs[i].name);
      repeat (vecs[i].t) tick();
      check(vecs[i].name, obs, vecs[i].exp);
    end

    // T3: word width 16 -> 32 at slot 0 bit 5; current frame must stay 16-bit
    start(2'd0, 5'd2, 6'd16, 7'd1, "t3_start");
    glitch = 0;
    extra  = 0;
    for (int t = 1; t <= 192; t++) begin
      if (t == 11) ww = 6'd32;
      tick();
      if (bclk !== t[0]) glitch++;
      if (fs === 1'b1 && t != 64 && t != 192) extra++;
      if (t == 62)  check("t3_old_last_bit", obs, ex(0, 0, 1, 0, 0, 1, 15));
      if (t == 64)  check("t3_new_fs", obs, ex(0, 0, 1, 0, 1, 0, 0));
      if (t == 126) check("t3_new_s0b31", obs, ex(0, 1, 1, 0, 0, 0, 31));
      if (t == 192) check("t3_second_fs", {31'd0, fs}, 1);
    end
    check("t3_bclk_glitch", glitch, 0);
    check("t3_extra_fs", extra, 0);

    // T4: disable at slot 1 bit 3; frame completes, then stop and restart
    start(2'd0, 5'd2, 6'd8, 7'd1, "t4_start");
    for (int t = 1; t <= 33; t++) begin
      if (t == 23) enable = 1'b0;
      tick();
      if (t == 31) check("t4_last_bit", obs, ex(1, 0, 0, 1, 0, 1, 7));
      if (t == 32) check("t4_stop", {fs, running, bclk}, 3'b010);
      if (t == 33) check("t4_idle", {running, bclk, lrck}, 3'b000);
    end
    enable = 1'b1;
    wait_fs("t4_restart", ok, cyc);
    check("t4_restart_lat", cyc, 2);
    check("t4_restart_out", {obs, running}, {ex(0, 0, 1, 0, 1, 0, 0), 1'b1});

    // T5: invalid configs in IDLE, then an invalid change while running
    rst_n  = 1'b0;
    enable = 1'b0;
    div = 7'd0; ch = 5'd2; ww = 6'd32; fmt = 2'd0;
    #2;
    rst_n  = 1'b1;
    enable = 1'b1;
    pulses = 0;
    run_seen = 0;
    repeat (12) begin
      tick();
      if (cfg_err === 1'b1) pulses++;
      if (running === 1'b1) run_seen++;
    end
    check("t5_div0_pulses", pulses, 1);
    check("t5_div0_running", run_seen, 0);
    div = 7'd2;
    ch  = 5'd3;
    pulses = 0;
    repeat (12) begin
      tick();
      if (cfg_err === 1'b1) pulses++;
      if (running === 1'b1) run_seen++;
    end
    check("t5_ch3_pulses", pulses, 1);
    check("t5_ch3_running", run_seen, 0);
    ch = 5'd2;
    wait_fs("t5_valid_start", ok, cyc);
    pulses = 0;
    for (int t = 1; t <= 258; t++) begin
      if (t == 6) div = 7'd0;
      tick();
      if (cfg_err === 1'b1) pulses++;
      if (t == 256) check("t5_run_err_at_fs", {fs, cfg_err}, 2'b11);
      if (t == 258) check("t5_old_timing", {bclk, rise}, 2'b11);
    end
    check("t5_run_pulses", pulses, 1);

    // T6: asynchronous reset mid-frame
    start(2'd0, 5'd2, 6'd32, 7'd2, "t6_start");
    repeat (38) tick();
    check("t6_mid_frame", obs, ex(1, 0, 0, 1, 0, 0, 9));
    #2 rst_n = 1'b0;
    #1 check("t6_async_clear", {obs, running, cfg_err}, 0);
    #1 rst_n = 1'b1;
    tick();
    check("t6_fs_not_yet", {31'd0, fs}, 0);
    tick();
    check("t6_fs_two_cycles", obs, ex(0, 0, 1, 0, 1, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
